// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - sequential ALU with iterative shift-add multiplier and ARM-style flags
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_err,
  output logic             c_flag,
  output logic             z_flag,
  output logic             n_flag,
  output logic             v_flag
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} stateT;

  stateT            state, nextState;
  logic             accept;
  logic             isMulOp;
  logic             isArith;
  logic             isLegal;
  logic [WIDTH-1:0] addX, addY;
  logic             addCin;
  logic [WIDTH:0]   addSum;
  logic             addV;
  logic [WIDTH-1:0] aluRes;
  logic [WIDTH-1:0] mulA, mulB, mulAcc, mulStep;
  logic [CW-1:0]    mulCnt;
  logic             mulS;

  assign isMulOp = (op == 5'd12);
  assign isArith = (op >= 5'd4) && (op <= 5'd9);
  assign isLegal = (op <= 5'd12);

  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    case (state)
      IDLE: if (accept) nextState = isMulOp ? MUL : HOLD;
      MUL:  if (mulCnt == LAST_CNT) nextState = HOLD;
      HOLD: begin
        if (accept)         nextState = isMulOp ? MUL : HOLD;
        else if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign out_valid = (state == HOLD);

  // Every subtract form is x + ~y + cin, so C falls out as NOT-borrow.
  always_comb begin
    addX   = a;
    addY   = b;
    addCin = 1'b0;
    case (op)
      5'd5: addCin = c_flag;
      5'd6: begin addY = ~b; addCin = 1'b1; end
      5'd7: begin addY = ~b; addCin = c_flag; end
      5'd8: begin addX = b; addY = ~a; addCin = 1'b1; end
      5'd9: begin addX = b; addY = ~a; addCin = c_flag; end
      default: ;
    endcase
    addSum = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addCin};
    addV   = (addX[WIDTH-1] == addY[WIDTH-1]) && (addSum[WIDTH-1] != addX[WIDTH-1]);
  end

  always_comb begin
    aluRes = '0;
    case (op)
      5'd0:  aluRes = a & b;
      5'd1:  aluRes = a & ~b;
      5'd2:  aluRes = a | b;
      5'd3:  aluRes = a ^ b;
      5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9: aluRes = addSum[WIDTH-1:0];
      5'd10: aluRes = b;
      5'd11: aluRes = ~b;
      default: aluRes = '0;
    endcase
  end

  assign mulStep = mulAcc + (mulB[0] ? mulA : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result  <= '0;
      out_err <= 1'b0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      n_flag  <= 1'b0;
      v_flag  <= 1'b0;
      mulA    <= '0;
      mulB    <= '0;
      mulAcc  <= '0;
      mulCnt  <= '0;
      mulS    <= 1'b0;
    end else if (state == MUL) begin
      if (mulCnt == LAST_CNT) begin
        result  <= mulStep;
        out_err <= 1'b0;
        if (mulS) begin
          n_flag <= mulStep[WIDTH-1];
          z_flag <= (mulStep == '0);
        end
      end else begin
        mulAcc <= mulStep;
        mulA   <= mulA << 1;
        mulB   <= mulB >> 1;
        mulCnt <= mulCnt + CW'(1);
      end
    end else if (accept) begin
      if (isMulOp) begin
        mulA   <= a;
        mulB   <= b;
        mulAcc <= '0;
        mulCnt <= '0;
        mulS   <= s_bit;
      end else if (isLegal) begin
        result  <= aluRes;
        out_err <= 1'b0;
        if (s_bit) begin
          n_flag <= aluRes[WIDTH-1];
          z_flag <= (aluRes == '0);
          if (isArith) begin
            c_flag <= addSum[WIDTH];
            v_flag <= addV;
          end
        end
      end else begin
        result  <= '0;
        out_err <= 1'b1;
      end
    end
  end

endmodule
